// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic elastic pipeline stage register.
// Carries a PC word plus an opaque payload bus behind a valid/ready handshake
// on both sides, with global stall (highest priority) and flush controls.
// Build option PIPE_STAGE_SKID_EN: when defined the stage holds up to two
// entries (main + skid) so that in_ready has no combinational path from
// out_ready; when undefined it is a single register whose in_ready looks at
// out_ready directly.
module pipe_stage_reg #(
    parameter int                 DATA_W    = 107,
    parameter int                 PC_W      = 30,
    parameter logic [DATA_W-1:0]  NOP_VALUE = {DATA_W{1'b0}}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    // Occupancy-coded states; any other encoding is treated as illegal.
    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_BUSY  = 2'b01;
    localparam logic [1:0] ST_FULL  = 2'b10;

    logic [1:0]        r_state;
    logic [PC_W-1:0]   r_main_pc;
    logic [DATA_W-1:0] r_main_data;

    logic [1:0]        w_state_nxt;
    logic              w_acc;
    logic              w_pop;
    logic              w_clear;
    logic              w_load_main;
    logic              w_main_from_skid;
    logic              w_load_skid;

`ifdef PIPE_STAGE_SKID_EN
    logic [PC_W-1:0]   r_skid_pc;
    logic [DATA_W-1:0] r_skid_data;
`endif

    // Decode the visible valid flag and entry count from the state register.
    always_comb begin
        out_valid = 1'b0;
        occupancy = 2'd0;
        case (r_state)
            ST_EMPTY: begin
                out_valid = 1'b0;
                occupancy = 2'd0;
            end
            ST_BUSY: begin
                out_valid = 1'b1;
                occupancy = 2'd1;
            end
            ST_FULL: begin
                out_valid = 1'b1;
                occupancy = 2'd2;
            end
            default: begin
                out_valid = 1'b0;
                occupancy = 2'd0;
            end
        endcase
    end

    // Upstream ready: with the skid entry it depends only on state and stall,
    // without it the single register may refill in the cycle it is drained.
    always_comb begin
`ifdef PIPE_STAGE_SKID_EN
        in_ready = ~stall & (r_state != ST_FULL);
`else
        in_ready = ~stall & (~out_valid | out_ready);
`endif
    end

    // Handshake events; stall suppresses the downstream pop explicitly.
    always_comb begin
        w_acc = in_valid & in_ready;
        w_pop = out_valid & out_ready & ~stall;
    end

    // Next-state and register-load decisions. Stall freezes everything,
    // flush (when not stalled) empties the stage and drops any same-cycle acc.
    always_comb begin
        w_state_nxt      = r_state;
        w_clear          = 1'b0;
        w_load_main      = 1'b0;
        w_main_from_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (stall) begin
            w_state_nxt = r_state;
        end else if (flush) begin
            w_clear     = 1'b1;
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_acc) begin
                        w_load_main = 1'b1;
                        w_state_nxt = ST_BUSY;
                    end else begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_BUSY: begin
`ifdef PIPE_STAGE_SKID_EN
                    if (w_acc && !w_pop) begin
                        // Younger entry parks in the skid register.
                        w_load_skid = 1'b1;
                        w_state_nxt = ST_FULL;
                    end else if (w_acc && w_pop) begin
                        w_load_main = 1'b1;
                        w_state_nxt = ST_BUSY;
                    end else if (w_pop) begin
                        w_state_nxt = ST_EMPTY;
                    end else begin
                        w_state_nxt = ST_BUSY;
                    end
`else
                    // Without a skid entry an acc here always coincides with a pop.
                    if (w_acc) begin
                        w_load_main = 1'b1;
                        w_state_nxt = ST_BUSY;
                    end else if (w_pop) begin
                        w_state_nxt = ST_EMPTY;
                    end else begin
                        w_state_nxt = ST_BUSY;
                    end
`endif
                end
                ST_FULL: begin
`ifdef PIPE_STAGE_SKID_EN
                    if (w_pop) begin
                        // Older entry leaves; skid entry becomes the head.
                        w_main_from_skid = 1'b1;
                        w_state_nxt      = ST_BUSY;
                    end else begin
                        w_state_nxt = ST_FULL;
                    end
`else
                    // Unreachable without a skid entry: recover to empty.
                    w_state_nxt = ST_EMPTY;
`endif
                end
                default: begin
                    // Illegal encoding: recover to a known empty stage.
                    w_state_nxt = ST_EMPTY;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Main (head) entry; loads only on a transfer, a skid promotion or a flush.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_main_pc   <= {PC_W{1'b0}};
            r_main_data <= NOP_VALUE;
        end else if (w_clear) begin
            r_main_pc   <= {PC_W{1'b0}};
            r_main_data <= NOP_VALUE;
        end else if (w_load_main) begin
            r_main_pc   <= in_pc;
            r_main_data <= in_data;
`ifdef PIPE_STAGE_SKID_EN
        end else if (w_main_from_skid) begin
            r_main_pc   <= r_skid_pc;
            r_main_data <= r_skid_data;
`endif
        end else begin
            r_main_pc   <= r_main_pc;
            r_main_data <= r_main_data;
        end
    end

`ifdef PIPE_STAGE_SKID_EN
    // Skid entry; always younger than the main entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_skid_pc   <= {PC_W{1'b0}};
            r_skid_data <= NOP_VALUE;
        end else if (w_clear) begin
            r_skid_pc   <= {PC_W{1'b0}};
            r_skid_data <= NOP_VALUE;
        end else if (w_load_skid) begin
            r_skid_pc   <= in_pc;
            r_skid_data <= in_data;
        end else begin
            r_skid_pc   <= r_skid_pc;
            r_skid_data <= r_skid_data;
        end
    end
`else
    // Skid promotion and skid load never occur in the single-register build.
    logic w_unused_skid;
    always_comb begin
        w_unused_skid = w_main_from_skid | w_load_skid;
    end
`endif

    // Head entry drives the outputs straight from registers.
    always_comb begin
        out_pc   = r_main_pc;
        out_data = r_main_data;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic, parametrised pipeline stage register for the next-generation CPU pipeline; replaces the fixed-field per-stage registers (IF/ID, ID/EX, EX/MEM).
- Carries a PC word plus an opaque payload bus of configurable width.
- Adds a valid/ready elastic handshake on both sides and a two-entry skid buffer, so back-pressure never drops an instruction and ready never has a combinational path from out_ready.
- Keeps the existing global stall/flush controls, with stall priority over flush.

Parameters:
- DATA_W, 107, payload width in bits (concatenated decoded control fields).
- PC_W, 30, word-address PC width.
- NOP_VALUE, {DATA_W{1'b0}}, payload value loaded on reset and flush (encodes all-NOP controls).

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  global hold; freezes all state and blocks both handshakes.
- flush  in  1  discard contents; honoured only when stall=0.
- in_valid  in  1  upstream has an entry.
- in_ready  out  1  stage can accept this cycle.
- in_pc  in  PC_W  upstream PC.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  stage holds a valid entry.
- out_ready  in  1  downstream accepts.
- out_pc  out  PC_W  PC of the head entry.
- out_data  out  DATA_W  payload of the head entry.
- occupancy  out  2  entries held (0..2).

Behaviour:
- Handshake events:
  - acc = in_valid & in_ready.
  - pop = out_valid & out_ready & ~stall.
  - A transfer occurs only on a rising clk edge with the event high.
- Reset (reset=0, asynchronous):
  - State EMPTY; out_valid=0; out_pc=0; out_data=NOP_VALUE; skid register = 0/NOP_VALUE; occupancy=0.
- State machine (two-bit state register), with out_valid=1 in BUSY and FULL:
  - EMPTY (occ 0): acc → BUSY, main register <= in. Otherwise stay.
  - BUSY (occ 1):
    - acc & ~pop → FULL, skid register <= in.
    - acc & pop → BUSY, main register <= in.
    - ~acc & pop → EMPTY.
    - Otherwise hold.
  - FULL (occ 2): pop → BUSY, main register <= skid register. Otherwise hold. acc is impossible in this state.
- in_ready = ~stall & (state != FULL). Decoded from state and stall only, with no out_ready path.
- Latency: 1 cycle from acc to out_valid when EMPTY. Throughput: 1 entry per cycle under continuous out_ready.
- Ordering: strict FIFO; the skid entry is always younger than the main entry.
- stall=1:
  - No state or data change.
  - in_ready=0; pop is suppressed even if out_ready=1.
  - out_valid, out_pc and out_data stay stable and visible.
- flush=1 & stall=0:
  - Next edge → EMPTY; main and skid registers <= 0/NOP_VALUE.
  - Any acc in the same cycle is discarded. A same-cycle pop is still counted as consumed downstream.
- flush=1 & stall=1: flush is ignored (not latched). Flush takes effect only in a later cycle with stall=0.
- Reset asserted mid-operation clears both entries immediately. No partial transfer completes.
- Data registers load only on a transfer or flush. They never change while in_valid toggles without acc.

Optional Feature:
- Macro PIPE_STAGE_SKID_EN.
- Defined: two-entry skid behaviour exactly as above; occupancy ranges 0..2.
- Undefined:
  - Single register; no FULL state, no skid register.
  - in_ready = ~stall & (~out_valid | out_ready), a combinational path from out_ready.
  - occupancy ranges 0..1.
  - All reset, flush and stall rules are unchanged.

Test Plan:
- Reset release, in_valid=1, pc=0x10, data=0xA5, out_ready=1 → out_valid=1 next cycle with pc=0x10, data=0xA5. Continuous stream 0x10..0x17 exits one per cycle, in order.
- Stream pc 0x20,0x21,0x22 with out_ready=0 → occupancy 1 then 2, in_ready=0 after the second acc, 0x22 held upstream. Raise out_ready → outputs 0x20,0x21,0x22 in order with no loss.
- FULL state, stall=1 for 3 cycles with out_ready=1 → out_pc stays 0x20, occupancy 2, in_ready=0. Release → drain resumes.
- occupancy 2, flush=1 & stall=0 → next cycle out_valid=0, out_data=NOP_VALUE, occupancy 0. A simultaneous in_valid entry is dropped.
- flush=1 & stall=1 for 1 cycle → no change. Then flush=0 & stall=0 → entries preserved.
- reset=0 asserted asynchronously mid-stream between clock edges → out_valid=0 and occupancy=0 without waiting for clk.
